spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
- SPI mode-0, write-only target. Sits directly upstream of the PWM peripheral and drives its five configuration registers.
- Receives 16-bit frames from an external controller on ui_in pins. Decodes each frame and commits it to one register only when the whole frame is valid.
- Register outputs connect straight to the PWM peripheral's en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle inputs.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer chain (minimum 2)
MAX_ADDR, 4, highest writable register address; frames addressed above this are rejected

Ports:
clk  input  1  system clock, the only clock
rst  input  1  asynchronous reset, active-high
sclk  input  1  SPI clock from pin, asynchronous to clk
copi  input  1  SPI data in from pin, asynchronous to clk
ncs  input  1  SPI chip select from pin, active-low, asynchronous to clk
en_reg_out_7_0  output  8  register at address 0x00
en_reg_out_15_8  output  8  register at address 0x01
en_reg_pwm_7_0  output  8  register at address 0x02
en_reg_pwm_15_8  output  8  register at address 0x03
pwm_duty_cycle  output  8  register at address 0x04
frame_err  output  1  one-clk pulse when a malformed frame ends

Behaviour:
- Reset: all five registers = 0x00, frame_err = 0, bit counter = 0, shift register = 0, state IDLE.
  - Synchronizer flops reset to sclk=0, copi=0, ncs=1.
  - Reset is asynchronous assert; all flops clocked by clk.
- Synchronization:
  - Each pin passes through a SYNC_STAGES-flop chain, then one more history flop for edge detection.
  - sclk_rise = sync & ~hist. ncs_fall and ncs_rise are derived the same way.
- Timing constraint: sclk high and low phases are each at least 3 clk periods; ncs is held high at least 3 clk periods between frames. Operation outside this is not required.
- Frame format, MSB first:
  - bit15: 1 = write, 0 = read (reads are not supported).
  - bits14:8: address (7 bits).
  - bits7:0: data.
- State machine:
  - IDLE → RECV on ncs_fall. Clears the shift register and bit counter.
  - RECV, on each sclk_rise while synchronized ncs = 0:
    - shift = {shift[14:0], copi_sync};
    - bit counter increments and saturates at 17.
  - RECV → COMMIT on ncs_rise.
  - COMMIT, for exactly one cycle, then → IDLE:
    - count==16, bit15=1, addr<=MAX_ADDR: write data to the addressed register.
    - count==16, bit15=0: no write, no error.
    - count!=16, or (bit15=1 and addr>MAX_ADDR): no write; frame_err=1 for this one cycle.
- Write latency: the register output changes on the clk edge that ends the COMMIT cycle. With SYNC_STAGES=2 this is the 4th rising clk edge after the first edge that samples ncs=1. The bench checks at edge 5.
- sclk edges seen while in IDLE are ignored.
- Only one register changes per frame; all other registers hold.
- Reset mid-frame:
  - Registers clear.
  - ncs_sync restarts at 1, so a still-low ncs is seen as a fresh ncs_fall. The partial frame then ends with count<16, giving frame_err and no write.
- ncs_rise and sclk_rise in the same cycle: ncs_rise wins and the sclk edge is not shifted.

Test Plan:
- Assert rst for 3 cycles with random pins → all five registers 0x00 and frame_err 0, during and after reset.
- Frame 0x80F0, then 0x8480 → en_reg_out_7_0=0xF0 and pwm_duty_cycle=0x80, each by edge 5 after ncs rises; other registers stay 0x00.
- Read frame 0x0155 after setting en_reg_out_15_8=0x33 via 0x8133 → en_reg_out_15_8 stays 0x33, frame_err stays 0.
- Frame 0x85AA (addr 5) → no register changes; frame_err high for exactly 1 cycle.
- 15-bit frame 0x4078 and 17-bit frame carrying 0x82FF plus one extra bit → no writes, one frame_err pulse each.
- Pulse rst after 8 bits of 0x83C3 with ncs held low; raise ncs → registers 0x00 and one frame_err. Next full 0x83C3 → en_reg_pwm_15_8=0xC3.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only target that receives 16-bit frames and drives the five
// PWM configuration registers; malformed frames raise a one-cycle frame_err.
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT
    } state_t;

    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] COUNT_MAX  = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] copi_ff;
    logic [SYNC_STAGES-1:0] ncs_ff;
    logic                   sclk_hist;
    logic                   ncs_hist;

    logic sclk_sync;
    logic copi_sync;
    logic ncs_sync;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    state_t      state;
    logic [15:0] shift;
    logic [4:0]  count;
    logic [6:0]  addr;
    logic        addr_ok;
    logic        frame_ok;

    // Synchronizers reset to the idle bus levels so no edge is seen on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_ff   <= '0;
            copi_ff   <= '0;
            ncs_ff    <= '1;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b1;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            copi_ff   <= {copi_ff[SYNC_STAGES-2:0], copi};
            ncs_ff    <= {ncs_ff[SYNC_STAGES-2:0], ncs};
            sclk_hist <= sclk_ff[SYNC_STAGES-1];
            ncs_hist  <= ncs_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_sync = sclk_ff[SYNC_STAGES-1];
    assign copi_sync = copi_ff[SYNC_STAGES-1];
    assign ncs_sync  = ncs_ff[SYNC_STAGES-1];

    assign sclk_rise = sclk_sync & ~sclk_hist;
    assign ncs_fall  = ~ncs_sync & ncs_hist;
    assign ncs_rise  = ncs_sync & ~ncs_hist;

    assign addr     = shift[14:8];
    assign addr_ok  = int'(addr) <= MAX_ADDR;
    assign frame_ok = (count == FRAME_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shift           <= '0;
            count           <= '0;
            frame_err       <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        shift <= '0;
                        count <= '0;
                        state <= RECV;
                    end
                end

                RECV: begin
                    // A chip-select release takes priority over a coincident clock edge.
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && !ncs_sync) begin
                        shift <= {shift[14:0], copi_sync};
                        if (count != COUNT_MAX) begin
                            count <= count + 5'd1;
                        end
                    end
                end

                COMMIT: begin
                    state <= IDLE;
                    if (frame_ok && shift[15] && addr_ok) begin
                        case (addr)
                            7'd0:    en_reg_out_7_0  <= shift[7:0];
                            7'd1:    en_reg_out_15_8 <= shift[7:0];
                            7'd2:    en_reg_pwm_7_0  <= shift[7:0];
                            7'd3:    en_reg_pwm_15_8 <= shift[7:0];
                            7'd4:    pwm_duty_cycle  <= shift[7:0];
                            default: ;
                        endcase
                    end else if (!(frame_ok && !shift[15])) begin
                        frame_err <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: drives SPI frames on the pins and compares
// the register bank and frame_err pulse count against a reference model.
module tb_spi_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_err;

    spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [39:0] regs;
        int unsigned errs;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model[5];
    int unsigned err_total = 0;
    int unsigned err_base  = 0;
    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_total <= err_total + 1;
    end

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_regs();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one complete frame of n bits.
    task automatic predict(input string name, input logic [31:0] val, input int unsigned n);
        exp_t        e;
        int unsigned a;
        e.name = name;
        e.errs = 0;
        a = int'(val[14:8]);
        if (n == 16 && val[15] && a <= 4) model[a] = val[7:0];
        else if (!(n == 16 && !val[15])) e.errs = 1;
        e.regs = model_regs();
        sb.push_back(e);
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        err_base = err_total;
        ncs = 1'b0;
        wait_clks(4);
    endtask

    task automatic send_bits(input logic [31:0] val, input int unsigned n);
        for (int i = int'(n) - 1; i >= 0; i--) begin
            copi = val[i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
        wait_clks(4);
    endtask

    // Release chip select, then compare at the fifth clock edge and after the error window.
    task automatic end_frame();
        exp_t e;
        ncs = 1'b1;
        wait_clks(5);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, "_regs"}, 64'(dut_regs()), 64'(e.regs));
            wait_clks(3);
            check({e.name, "_err"}, 64'(err_total - err_base), 64'(e.errs));
        end
        wait_clks(2);
    endtask

    task automatic frame(input string name, input logic [31:0] val, input int unsigned n);
        predict(name, val, n);
        start_frame();
        send_bits(val, n);
        end_frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk = 1'($urandom);
            copi = 1'($urandom);
            ncs  = 1'($urandom);
            check("reset_regs", 64'(dut_regs()), 64'd0);
            check("reset_err", 64'(frame_err), 64'd0);
        end
        @(negedge clk);
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        rst  = 1'b0;
        err_base = err_total;
        wait_clks(6);
        check("post_reset_regs", 64'(dut_regs()), 64'd0);
        check("post_reset_err", 64'(err_total - err_base), 64'd0);

        frame("w_out_7_0", 32'h80F0, 16);
        frame("w_duty", 32'h8480, 16);
        frame("w_out_15_8", 32'h8133, 16);
        frame("read", 32'h0155, 16);
        frame("bad_addr", 32'h85AA, 16);
        frame("short15", 32'h4078, 15);
        frame("long17", 32'h105FF, 17);

        // Reset with chip select still low: restarts as a partial frame.
        start_frame();
        send_bits(32'h83, 8);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        predict("mid_reset", 32'h0, 0);
        wait_clks(6);
        end_frame();

        frame("w_pwm_15_8", 32'h83C3, 16);

        if (sb.size() != 0) check("scoreboard_left", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
